// File: rtl/conbus_pkg.sv
// rtl/conbus_pkg.sv - shared widths, arbiter state encoding and helpers for conbus_rr
//   WB_AW / WB_DW / WB_SW : Wishbone address, data and byte-select widths
//   ERR_CNT_W             : width of the saturating error counter
//   arb_state_e           : arbiter state (ARB_IDLE / ARB_BUSY)
package conbus_pkg;

  localparam int WB_AW     = 32;
  localparam int WB_DW     = 32;
  localparam int WB_SW     = 4;
  localparam int ERR_CNT_W = 8;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/conbus_rr_arbiter.sv
// rtl/conbus_rr_arbiter.sv - round-robin grant holder for the shared Wishbone path
//   clk_i, rst_i : clock, synchronous active-high reset
//   cyc_i        : per-master cycle requests
//   grant_o      : index of the owning master (valid while busy_o)
//   busy_o       : a master owns the bus
module conbus_rr_arbiter
  import conbus_pkg::*;
#(
  parameter int NM = 2,
  localparam int GW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [NM-1:0] cyc_i,
  output logic [GW-1:0] grant_o,
  output logic          busy_o
);

  arb_state_e    state_q;
  logic [GW-1:0] last_q;
  logic [GW-1:0] grant_q;
  logic [GW-1:0] grant_d;

  // First requester strictly after the previous winner, wrapping around;
  // the previous winner itself is considered last.
  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    grant_d = last_q;
    for (int i = 1; i <= NM; i++) begin
      idx = (int'(last_q) + i) % NM;
      if (!found && cyc_i[GW'(idx)]) begin
        found   = 1'b1;
        grant_d = GW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      last_q  <= GW'(NM - 1);
      grant_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (|cyc_i) begin
            state_q <= ARB_BUSY;
            grant_q <= grant_d;
            last_q  <= grant_d;
          end
        end
        ARB_BUSY: begin
          if (!cyc_i[grant_q]) begin
            state_q <= ARB_IDLE;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == ARB_BUSY);

endmodule

// File: rtl/conbus_rr.sv
// rtl/conbus_rr.sv - NM-master / NS-slave shared Wishbone bus, round-robin, with error termination
//   sys_clk, sys_rst          : clock, synchronous active-high reset
//   m_*_i / m_dat_o, m_ack_o, m_err_o : master side (packed per-master vectors)
//   s_*_o / s_dat_i, s_ack_i  : slave side (cyc/stb one-hot, rest broadcast)
//   err_adr_o, err_cnt_o      : last errored address, saturating error count
module conbus_rr
  import conbus_pkg::*;
#(
  parameter int                     NM       = 2,
  parameter int                     NS       = 5,
  parameter int                     S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDR   = {3'b100, 3'b011, 3'b010, 3'b001, 3'b000},
  parameter int                     TIMEOUT  = 255
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [NM*WB_AW-1:0]  m_adr_i,
  input  logic [NM*WB_DW-1:0]  m_dat_i,
  input  logic [NM*WB_SW-1:0]  m_sel_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  output logic [WB_DW-1:0]     m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [WB_AW-1:0]     s_adr_o,
  output logic [WB_DW-1:0]     s_dat_o,
  output logic [WB_SW-1:0]     s_sel_o,
  output logic                 s_we_o,
  output logic [NS-1:0]        s_cyc_o,
  output logic [NS-1:0]        s_stb_o,
  input  logic [NS*WB_DW-1:0]  s_dat_i,
  input  logic [NS-1:0]        s_ack_i,
  output logic [WB_AW-1:0]     err_adr_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int GW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW  = (NS > 1) ? $clog2(NS) : 1;
  // Wide enough to hold TIMEOUT itself.
  localparam int WCW = $clog2(TIMEOUT + 1) + 1;

  logic [GW-1:0]        grant;
  logic                 busy;
  logic [WB_AW-1:0]     own_adr;
  logic                 own_cyc;
  logic                 own_stb;
  logic [SW-1:0]        sel;
  logic                 miss;
  logic                 ack_sel;
  logic                 err_fire;

  logic [NM-1:0]        err_q,     err_d;
  logic [WCW-1:0]       wait_q,    wait_d;
  logic [WB_AW-1:0]     err_adr_q, err_adr_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  conbus_rr_arbiter #(
    .NM(NM)
  ) u_arbiter (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .cyc_i  (m_cyc_i),
    .grant_o(grant),
    .busy_o (busy)
  );

  assign own_adr = m_adr_i[grant*WB_AW +: WB_AW];
  assign own_cyc = busy & m_cyc_i[grant];
  assign own_stb = busy & m_stb_i[grant];

  // Descending scan so the lowest matching slave index wins.
  always_comb begin
    sel  = '0;
    miss = 1'b1;
    for (int k = NS - 1; k >= 0; k--) begin
      if (own_adr[WB_AW-1 -: S_ADDR_W] == S_ADDR[k*S_ADDR_W +: S_ADDR_W]) begin
        sel  = SW'(k);
        miss = 1'b0;
      end
    end
  end

  assign ack_sel = own_stb & ~miss & s_ack_i[sel];

  always_comb begin
    s_cyc_o = '0;
    s_stb_o = '0;
    m_ack_o = '0;
    m_dat_o = '0;
    if (busy && !miss) begin
      s_cyc_o[sel] = own_cyc;
      s_stb_o[sel] = own_stb;
      m_dat_o      = s_dat_i[sel*WB_DW +: WB_DW];
    end
    m_ack_o[grant] = ack_sel;
  end

  assign s_adr_o = busy ? own_adr : '0;
  assign s_dat_o = busy ? m_dat_i[grant*WB_DW +: WB_DW] : '0;
  assign s_sel_o = busy ? m_sel_i[grant*WB_SW +: WB_SW] : '0;
  assign s_we_o  = busy & m_we_i[grant];

  // The cycle in which err is presented terminates the access: it neither
  // fires again nor counts toward a timeout, even though stb is still high.
  // A same-cycle ack beats a timeout.
  assign err_fire = own_stb & ~(|err_q) &
                    (miss | ((TIMEOUT != 0) & ~ack_sel & (wait_q == WCW'(TIMEOUT))));

  always_comb begin
    err_d     = '0;
    err_adr_d = err_adr_q;
    err_cnt_d = err_cnt_q;
    if (err_fire) begin
      err_d[grant] = 1'b1;
      err_adr_d    = own_adr;
      err_cnt_d    = sat_inc(err_cnt_q);
    end
    if (!own_stb || ack_sel || miss || (|err_q) || err_fire || (TIMEOUT == 0)) begin
      wait_d = '0;
    end else begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q     <= '0;
      wait_q    <= '0;
      err_adr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      wait_q    <= wait_d;
      err_adr_q <= err_adr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign m_err_o   = err_q;
  assign err_adr_o = err_adr_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_conbus_rr.sv
// tb/tb_conbus_rr.sv - directed self-checking bench for conbus_rr (NM=2, NS=5, TIMEOUT=4)
module tb_conbus_rr;

  localparam int NM = 2;
  localparam int NS = 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM*32-1:0]  m_adr;
  logic [NM*32-1:0]  m_dat;
  logic [NM*4-1:0]   m_sel;
  logic [NM-1:0]     m_we;
  logic [NM-1:0]     m_cyc;
  logic [NM-1:0]     m_stb;
  logic [31:0]       m_rdat;
  logic [NM-1:0]     m_ack;
  logic [NM-1:0]     m_err;
  logic [31:0]       s_adr;
  logic [31:0]       s_dat;
  logic [3:0]        s_sel;
  logic              s_we;
  logic [NS-1:0]     s_cyc;
  logic [NS-1:0]     s_stb;
  logic [NS*32-1:0]  s_rdat;
  logic [NS-1:0]     s_ack;
  logic [NS-1:0]     ack_man;
  logic              auto_ack;
  logic [31:0]       err_adr;
  logic [7:0]        err_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign s_ack = auto_ack ? s_stb : ack_man;

  conbus_rr #(
    .TIMEOUT(4)
  ) dut (
    .sys_clk  (clk),
    .sys_rst  (rst),
    .m_adr_i  (m_adr),
    .m_dat_i  (m_dat),
    .m_sel_i  (m_sel),
    .m_we_i   (m_we),
    .m_cyc_i  (m_cyc),
    .m_stb_i  (m_stb),
    .m_dat_o  (m_rdat),
    .m_ack_o  (m_ack),
    .m_err_o  (m_err),
    .s_adr_o  (s_adr),
    .s_dat_o  (s_dat),
    .s_sel_o  (s_sel),
    .s_we_o   (s_we),
    .s_cyc_o  (s_cyc),
    .s_stb_o  (s_stb),
    .s_dat_i  (s_rdat),
    .s_ack_i  (s_ack),
    .err_adr_o(err_adr),
    .err_cnt_o(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic c, input logic s, input logic [31:0] a);
    m_cyc[m]         = c;
    m_stb[m]         = s;
    m_adr[m*32 +: 32] = a;
  endtask

  task automatic miss_txn();
    set_m(0, 1'b1, 1'b1, 32'hE000_0000);
    step();
    step();
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();
  endtask

  int         exp_rr [13] = '{0, 1, 0, 0, 2, 0, 0, 1, 0, 0, 2, 0, 0};
  logic [1:0] off;
  logic [1:0] got_ack;

  initial begin
    m_adr    = '0;
    m_dat    = '0;
    m_sel    = '1;
    m_we     = 2'b10;
    m_cyc    = '0;
    m_stb    = '0;
    ack_man  = '0;
    auto_ack = 1'b0;
    for (int k = 0; k < NS; k++) s_rdat[k*32 +: 32] = 32'hD000_0000 + k;
    m_dat[32 +: 32] = 32'h5A5A_0001;

    // Reset with a request pending: still no grant.
    set_m(0, 1'b1, 1'b1, 32'h2000_0004);
    repeat (2) step();
    chk("rst_cyc",    32'(s_cyc), 32'h0);
    chk("rst_stb",    32'(s_stb), 32'h0);
    chk("rst_ack",    32'(m_ack), 32'h0);
    chk("rst_err",    32'(m_err), 32'h0);
    chk("rst_adr",    s_adr, 32'h0);
    chk("rst_rdat",   m_rdat, 32'h0);
    chk("rst_errcnt", 32'(err_cnt), 32'h0);
    chk("rst_erradr", err_adr, 32'h0);
    set_m(0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step();

    // Single master 1 to slave 1, ack two cycles after stb.
    set_m(1, 1'b1, 1'b1, 32'h2000_0004);
    #1;
    chk("sm_prestb", 32'(s_stb), 32'h0);
    step();
    chk("sm_stb",  32'(s_stb), 32'h2);
    chk("sm_cyc",  32'(s_cyc), 32'h2);
    chk("sm_adr",  s_adr, 32'h2000_0004);
    chk("sm_wdat", s_dat, 32'h5A5A_0001);
    chk("sm_sel",  32'(s_sel), 32'hF);
    chk("sm_we",   32'(s_we), 32'h1);
    chk("sm_ack0", 32'(m_ack), 32'h0);
    step();
    chk("sm_ack1", 32'(m_ack), 32'h0);
    step();
    ack_man = 5'b00010;
    #1;
    chk("sm_ack",  32'(m_ack), 32'h2);
    chk("sm_rdat", m_rdat, 32'hD000_0001);
    step();
    set_m(1, 1'b0, 1'b0, 32'h0);
    ack_man = '0;
    #1;
    chk("sm_noerr", 32'(m_err), 32'h0);
    step();
    chk("sm_idle", 32'(s_cyc), 32'h0);

    // Unmapped address.
    set_m(0, 1'b1, 1'b1, 32'hE000_0000);
    step();
    chk("miss_cyc",  32'(s_cyc), 32'h0);
    chk("miss_err0", 32'(m_err), 32'h0);
    chk("miss_rdat", m_rdat, 32'h0);
    step();
    chk("miss_err",    32'(m_err), 32'h1);
    chk("miss_erradr", err_adr, 32'hE000_0000);
    chk("miss_errcnt", 32'(err_cnt), 32'h1);
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();
    chk("miss_pulse", 32'(m_err), 32'h0);

    // Timeout with a silent slave 0: err exactly 5 cycles after stb.
    set_m(0, 1'b1, 1'b1, 32'h0000_0010);
    step();
    chk("to_stb", 32'(s_stb), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("to_wait", 32'(m_err), 32'h0);
    end
    step();
    chk("to_err",    32'(m_err), 32'h1);
    chk("to_errcnt", 32'(err_cnt), 32'h2);
    chk("to_erradr", err_adr, 32'h0000_0010);
    set_m(0, 1'b0, 1'b0, 32'h0);
    step();
    chk("to_pulse", 32'(m_err), 32'h0);

    // Ack on the 5th cycle beats the timeout.
    set_m(0, 1'b1, 1'b1, 32'h0000_0010);
    step();
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("a5_wait", 32'(m_err), 32'h0);
    end
    step();
    ack_man = 5'b00001;
    #1;
    chk("a5_ack", 32'(m_ack), 32'h1);
    step();
    set_m(0, 1'b0, 1'b0, 32'h0);
    ack_man = '0;
    #1;
    chk("a5_noerr",  32'(m_err), 32'h0);
    chk("a5_errcnt", 32'(err_cnt), 32'h2);
    step();

    // Reset while master 0 owns the bus (last = 0 before reset).
    set_m(0, 1'b1, 1'b1, 32'h2000_0004);
    step();
    chk("rb_cyc", 32'(s_cyc), 32'h2);
    rst = 1'b1;
    step();
    chk("rb_cyc_rst", 32'(s_cyc), 32'h0);
    chk("rb_ack",     32'(m_ack), 32'h0);
    chk("rb_err",     32'(m_err), 32'h0);
    chk("rb_errcnt",  32'(err_cnt), 32'h0);
    set_m(0, 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    step();

    // Both masters, single-beat transfers with an auto-acking slave.
    auto_ack = 1'b1;
    off      = 2'b00;
    set_m(0, 1'b1, 1'b1, 32'h0000_0000);
    set_m(1, 1'b1, 1'b1, 32'h4000_0000);
    for (int c = 0; c < 13; c++) begin
      #1;
      got_ack = m_ack;
      chk("rr_ack", 32'(got_ack), 32'(exp_rr[c]));
      if (exp_rr[c] == 1) chk("rr_rdat0", m_rdat, 32'hD000_0000);
      if (exp_rr[c] == 2) chk("rr_rdat1", m_rdat, 32'hD000_0002);
      step();
      for (int m = 0; m < NM; m++) begin
        if (off[m])          off[m] = 1'b0;
        else if (got_ack[m]) off[m] = 1'b1;
        m_cyc[m] = ~off[m];
        m_stb[m] = ~off[m];
      end
    end
    auto_ack = 1'b0;
    m_cyc    = '0;
    m_stb    = '0;
    step();
    step();

    // Error counter saturation.
    for (int i = 0; i < 255; i++) miss_txn();
    chk("sat_255", 32'(err_cnt), 32'd255);
    miss_txn();
    chk("sat_hold",   32'(err_cnt), 32'd255);
    chk("sat_erradr", err_adr, 32'hE000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
